// File: rtl/flit_fifo_pkg.sv
// flit_fifo_pkg: shared flit buffer widths, depth and occupancy encoding
package flit_fifo_pkg;
    localparam int FLIT_WIDTH  = 128;
    localparam int NUM_ENTRIES = 8;
    typedef enum logic [1:0] {EMPTY, VACANT, ALMOST_FULL, FULL} buffer_state_t;
endpackage

// File: rtl/flit_fifo_if.sv
// flit_fifo_if: ready/valid write and read channels of the flit buffer
interface flit_fifo_if
    import flit_fifo_pkg::*;
#(
    parameter int WIDTH = FLIT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/flit_fifo_mem.sv
// flit_fifo_mem: register array, one synchronous write port, asynchronous read port
module flit_fifo_mem #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/flit_fifo.sv
// flit_fifo: parametrised first-word-fall-through flit FIFO with optional drop-on-full
module flit_fifo
    import flit_fifo_pkg::*;
#(
    parameter int WIDTH        = FLIT_WIDTH,
    parameter int DEPTH        = NUM_ENTRIES,
    parameter int AF_THRESH    = DEPTH - 1,
    parameter int DROP_ON_FULL = 0,
    localparam int AW          = $clog2(DEPTH),
    localparam int CW          = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          err_clr,
    flit_fifo_if.slave    link,
    output logic [CW-1:0] count,
    output buffer_state_t state,
    output logic          overflow,
    output logic [7:0]    drop_count
);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, push, pop, drop;
    assign full           = count == CW'(DEPTH);
    assign link.out_valid = count != '0;
    assign link.in_ready  = (DROP_ON_FULL != 0) || !full;
    assign push           = link.in_valid && !full;
    assign pop            = link.out_valid && link.out_ready;
    assign drop           = (DROP_ON_FULL != 0) && link.in_valid && full;
    always_comb
        state = count == '0              ? EMPTY :
                full                     ? FULL :
                count >= CW'(AF_THRESH)  ? ALMOST_FULL : VACANT;
    flit_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (link.in_data),
        .raddr (rd_ptr),
        .rdata (link.out_data)
    );
    // full+pop never admits a push, so count stays within 0..DEPTH
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // a drop in the same cycle as err_clr restarts the tally at one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            drop_count <= err_clr ? 8'd1 : drop_count + 8'(drop_count != 8'hff);
        end else if (err_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end
endmodule
